cpu_ctrl_sequencer: RTL

//  Controller-sequencer for the 8-bit SAP-style CPU. Drives the control word that the

---
 rtl/cpu_ctrl_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/cpu_ctrl_sequencer.sv
// SAP-style controller-sequencer: one-hot T1..T6 ring, fetch in T1-T3, opcode-decoded execute in T4-T6.
// Control word is combinational from the T-state, one instruction per 6 enabled cycles; run=0 or HLT stalls in place with all strobes low.
module cpu_ctrl_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_JMP = 4'h3,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic       cp,
   output logic       ep,
   output logic       po,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       ei,
   output logic       la,
   output logic       ea,
   output logic       lb,
   output logic       su,
   output logic       eu,
   output logic       lo,
   output logic       halted,
   output logic [5:0] tstate
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   tstate_e state_q, state_d;
   logic    halted_d;
   logic    active;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= T1;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         halted  <= halted_d;
      end
   end

   assign tstate = state_q;
   // Gating everything on active keeps the state frozen and the word zero together.
   assign active = run && !halted && !rst;

   always_comb begin
      state_d  = state_q;
      halted_d = halted;
      cp = 1'b0; ep = 1'b0; po = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
      la = 1'b0; ea = 1'b0; lb = 1'b0; su = 1'b0; eu = 1'b0; lo = 1'b0;
      if (active) begin
         case (state_q)
            T1: begin
               ep = 1'b1; lm = 1'b1;
               state_d = T2;
            end
            T2: begin
               cp = 1'b1;
               state_d = T3;
            end
            T3: begin
               ce = 1'b1; li = 1'b1;
               state_d = T4;
            end
            T4: begin
               state_d = T5;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                  OP_JMP: begin ei = 1'b1; po = 1'b1; end
                  OP_OUT: begin ea = 1'b1; lo = 1'b1; end
                  OP_HLT: begin
                     state_d  = T4;
                     halted_d = 1'b1;
                  end
                  default: ;
               endcase
            end
            T5: begin
               state_d = T6;
               case (opcode)
                  OP_LDA:         begin ce = 1'b1; la = 1'b1; end
                  OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                  default: ;
               endcase
            end
            T6: begin
               state_d = T1;
               case (opcode)
                  OP_ADD: begin eu = 1'b1; la = 1'b1; end
                  OP_SUB: begin su = 1'b1; eu = 1'b1; la = 1'b1; end
                  default: ;
               endcase
            end
            default: state_d = T1;
         endcase
      end
   end

endmodule
